// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and types for the load/store unit
package mem_pkg;

    localparam logic [1:0] MEM_OP_SIZE_BYTE      = 2'b00;
    localparam logic [1:0] MEM_OP_SIZE_HALF_WORD = 2'b01;
    localparam logic [1:0] MEM_OP_SIZE_WORD      = 2'b10;

    typedef enum logic [1:0] {
        OP_BYTE    = MEM_OP_SIZE_BYTE,
        OP_HALF    = MEM_OP_SIZE_HALF_WORD,
        OP_WORD    = MEM_OP_SIZE_WORD,
        OP_INVALID = 2'b11
    } op_size_e;

    // Address map: FLASH from 0 up to RAM_BASE, RAM, PERIPH, then RESERVED.
    localparam logic [31:0] FLASH_BASE  = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE    = 32'h2000_0000;
    localparam logic [31:0] PERIPH_BASE = 32'h3000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_BUS   = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte enables, store lane replication, load extract and extension
module lsu_lane_align
    import mem_pkg::*;
(
    input  op_size_e    size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [15:0] lane;

    // Select lanes by access size; the loaded value is shifted down to bit 0 then extended.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        lane    = 16'(rdata_i >> {offset_i, 3'b000});
        case (size_i)
            OP_BYTE: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & lane[7]}}, lane[7:0]};
            end
            OP_HALF: begin
                be_o    = 4'b0011 << offset_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{~unsigned_i & lane[15]}}, lane[15:0]};
            end
            OP_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit with fault decode and bus timeout
module load_store_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          FLASH_WRITABLE = 1'b0,
    parameter logic [31:0] RAM_TOP        = 32'h2fff_ffff,
    parameter logic [31:0] PERIPH_TOP     = 32'h3fff_ffff
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_write,
    input  logic        req_unsigned,
    input  logic [1:0]  req_op_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        op_fault,
    output logic        addr_fault,
    output logic        access_fault_n,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    lsu_state_e  state_q, state_d;

    logic        is_write_q;
    logic        unsigned_q;
    op_size_e    size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        op_fault_q;
    logic        addr_fault_q;
    logic        access_fault_n_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] tmo_cnt_q;

    logic        op_flt;
    logic        addr_flt;
    logic        region_flt;
    logic        check_flt;
    logic        in_flash;
    logic        in_ram;
    logic        in_periph;
    logic        timeout_hit;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    lsu_lane_align u_align (
        .size_i     (size_q),
        .offset_i   (addr_q[1:0]),
        .unsigned_i (unsigned_q),
        .wdata_i    (wdata_q),
        .rdata_i    (bus_rdata),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .rdata_o    (lane_rdata)
    );

    // Fault decode on the captured request and next-state selection.
    always_comb begin
        state_d     = state_q;
        op_flt      = (size_q == OP_INVALID);
        addr_flt    = ((size_q == OP_WORD) && (addr_q[1:0] != 2'b00)) ||
                      ((size_q == OP_HALF) && addr_q[0]);
        in_flash    = (addr_q < RAM_BASE);
        in_ram      = (addr_q >= RAM_BASE) && (addr_q <= RAM_TOP);
        in_periph   = (addr_q >= PERIPH_BASE) && (addr_q <= PERIPH_TOP);
        region_flt  = !(in_flash || in_ram || in_periph) ||
                      (is_write_q && in_flash && !FLASH_WRITABLE);
        check_flt   = op_flt || addr_flt || region_flt;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TIMEOUT_CYCLES - 1);
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = ST_CHECK;
            ST_CHECK: state_d = check_flt ? ST_RESP : ST_BUS;
            ST_BUS:   if (bus_err || bus_ack || timeout_hit) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Request capture, bus cycle control and response/flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_write_q       <= 1'b0;
            unsigned_q       <= 1'b0;
            size_q           <= OP_BYTE;
            addr_q           <= 32'h0;
            wdata_q          <= 32'h0;
            rsp_valid_q      <= 1'b0;
            rsp_data_q       <= 32'h0;
            op_fault_q       <= 1'b0;
            addr_fault_q     <= 1'b0;
            access_fault_n_q <= 1'b1;
            bus_req_q        <= 1'b0;
            bus_we_q         <= 1'b0;
            bus_be_q         <= 4'b0000;
            bus_addr_q       <= 32'h0;
            bus_wdata_q      <= 32'h0;
            tmo_cnt_q        <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_write_q <= req_is_write;
                        unsigned_q <= req_unsigned;
                        size_q     <= op_size_e'(req_op_size);
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                    end
                end
                ST_CHECK: begin
                    // Previous response is retired here; all applicable flags land together.
                    rsp_data_q       <= 32'h0;
                    op_fault_q       <= op_flt;
                    addr_fault_q     <= addr_flt;
                    access_fault_n_q <= ~region_flt;
                    if (check_flt) begin
                        rsp_valid_q <= 1'b1;
                    end else begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= is_write_q;
                        bus_be_q    <= lane_be;
                        bus_addr_q  <= {addr_q[31:2], 2'b00};
                        bus_wdata_q <= lane_wdata;
                        tmo_cnt_q   <= 32'h0;
                    end
                end
                ST_BUS: begin
                    if (bus_err) begin
                        bus_req_q        <= 1'b0;
                        access_fault_n_q <= 1'b0;
                        rsp_valid_q      <= 1'b1;
                    end else if (bus_ack) begin
                        bus_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        if (!is_write_q) rsp_data_q <= lane_rdata;
                    end else if (timeout_hit) begin
                        bus_req_q        <= 1'b0;
                        access_fault_n_q <= 1'b0;
                        rsp_valid_q      <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b0;
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign op_fault       = op_fault_q;
    assign addr_fault     = addr_fault_q;
    assign access_fault_n = access_fault_n_q;
    assign bus_req        = bus_req_q;
    assign bus_we         = bus_we_q;
    assign bus_be         = bus_be_q;
    assign bus_addr       = bus_addr_q;
    assign bus_wdata      = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_write;
    logic        req_unsigned;
    logic [1:0]  req_op_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        op_fault;
    logic        addr_fault;
    logic        access_fault_n;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT_CYCLES (TMO),
        .FLASH_WRITABLE (1'b0),
        .RAM_TOP        (32'h2fff_ffff),
        .PERIPH_TOP     (32'h3fff_ffff)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_write   (req_is_write),
        .req_unsigned   (req_unsigned),
        .req_op_size    (req_op_size),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .op_fault       (op_fault),
        .addr_fault     (addr_fault),
        .access_fault_n (access_fault_n),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_be         (bus_be),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_ack        (bus_ack),
        .bus_err        (bus_err),
        .bus_rdata      (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: address map, fault rules, lane arithmetic and extension.
    task automatic model(input bit wr, input bit uns, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input bit bus_fail,
                         output bit chk_f, output bit op_f, output bit addr_f, output bit acc_f,
                         output logic [3:0] be, output logic [31:0] wrep, output logic [31:0] rsp);
        int unsigned off;
        logic [31:0] v;
        bit reg_f;
        off    = a % 4;
        op_f   = (sz == 2'd3);
        addr_f = (sz == 2'd2 && off != 0) || (sz == 2'd1 && (a % 2) != 0);
        reg_f  = (a > 32'h3fff_ffff) || (wr && a < 32'h2000_0000);
        chk_f  = op_f || addr_f || reg_f;
        acc_f  = reg_f || (!chk_f && bus_fail);
        v      = rd >> (8 * off);
        case (sz)
            2'd0: begin
                be   = 4'(1 << off);
                wrep = (wd % 256) * 32'h0101_0101;
                v    = v % 256;
                if (!uns && v >= 128) v = v + 32'hffff_ff00;
            end
            2'd1: begin
                be   = 4'(3 << off);
                wrep = (wd % 65536) * 32'h0001_0001;
                v    = v % 65536;
                if (!uns && v >= 32768) v = v + 32'hffff_0000;
            end
            default: begin
                be   = 4'hf;
                wrep = wd;
                v    = rd;
            end
        endcase
        rsp = (chk_f || acc_f || wr) ? 32'h0 : v;
    endtask

    task automatic do_op(input string tag, input bit wr, input bit uns, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int wait_n, input bit err, input bit no_ack);
        bit chk_f, op_f, addr_f, acc_f, got;
        logic [3:0]  ebe;
        logic [31:0] ewd, ersp;
        int n, bus_cyc, lat, exp_lat, exp_bus;
        model(wr, uns, sz, a, wd, rd, err || no_ack, chk_f, op_f, addr_f, acc_f, ebe, ewd, ersp);
        exp_lat = chk_f ? 2 : (no_ack ? 2 + TMO : 3 + wait_n);
        exp_bus = chk_f ? 0 : (no_ack ? TMO : wait_n + 1);
        @(negedge clk);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_is_write = wr; req_unsigned = uns;
        req_op_size = sz; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_op_size = 2'($urandom); req_is_write = 1'($urandom); req_unsigned = 1'($urandom);
        n = 1; got = 1'b0; bus_cyc = 0; lat = 0;
        while (!got && n < 80) begin
            if (rsp_valid) begin
                got = 1'b1;
                lat = n;
            end else begin
                if (bus_req) begin
                    if (bus_cyc == 0) begin
                        check({tag, "_be"},    {28'b0, bus_be}, {28'b0, ebe});
                        check({tag, "_baddr"}, bus_addr, a & 32'hffff_fffc);
                        check({tag, "_we"},    {31'b0, bus_we}, {31'b0, wr});
                        check({tag, "_wdata"}, bus_wdata, ewd);
                    end
                    bus_cyc++;
                    if (!no_ack && bus_cyc == wait_n + 1) begin
                        bus_err   = err;
                        bus_ack   = err ? 1'($urandom) : 1'b1;
                        bus_rdata = rd;
                    end else begin
                        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
                    end
                end else begin
                    bus_ack = 1'b0; bus_err = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        bus_ack = 1'b0; bus_err = 1'b0;
        check({tag, "_rsp_seen"}, {31'b0, got}, 32'd1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_bus_cycles"}, bus_cyc, exp_bus);
        check({tag, "_op_fault"}, {31'b0, op_fault}, {31'b0, op_f});
        check({tag, "_addr_fault"}, {31'b0, addr_fault}, {31'b0, addr_f});
        check({tag, "_access_fault_n"}, {31'b0, access_fault_n}, {31'b0, !acc_f});
        check({tag, "_rsp_data"}, rsp_data, ersp);
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_held"}, rsp_data, ersp);
    endtask

    initial begin
        int r, pulses;
        logic [31:0] a;
        reset_n = 1'b0; req_valid = 1'b0; req_is_write = 1'b0; req_unsigned = 1'b0;
        req_op_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_flags", {29'b0, op_fault, addr_fault, access_fault_n}, 32'd1);
        check("rst_bus_ctl", {26'b0, bus_req, bus_we, bus_be}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        reset_n = 1'b1;

        do_op("ld_b_s",   1'b0, 1'b0, 2'd0, 32'h2000_0003, 32'h0, 32'h80ff_ffff, 0, 1'b0, 1'b0);
        do_op("ld_b_u",   1'b0, 1'b1, 2'd0, 32'h2000_0003, 32'h0, 32'h80ff_ffff, 0, 1'b0, 1'b0);
        do_op("st_h",     1'b1, 1'b0, 2'd1, 32'h2000_0002, 32'h0000_1234, 32'hdead_beef, 0, 1'b0, 1'b0);
        do_op("ld_w_mis", 1'b0, 1'b0, 2'd2, 32'h2000_0002, 32'h0, 32'h1111_1111, 0, 1'b0, 1'b0);
        do_op("st_flash", 1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h5555_aaaa, 32'h0, 0, 1'b0, 1'b0);
        do_op("ld_resv",  1'b0, 1'b0, 2'd2, 32'h4000_0000, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        do_op("ld_flash", 1'b0, 1'b0, 2'd1, 32'h0000_0102, 32'h0, 32'h8001_7fff, 1, 1'b0, 1'b0);
        do_op("bad_size", 1'b0, 1'b0, 2'd3, 32'h4000_0001, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        do_op("timeout",  1'b0, 1'b0, 2'd2, 32'h3000_0010, 32'h0, 32'h0, 0, 1'b0, 1'b1);
        do_op("bus_err",  1'b1, 1'b0, 2'd0, 32'h3000_0001, 32'h0000_00a5, 32'h0, 2, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 3);
            a = (r == 3) ? 32'h4000_0000 | ($urandom % 32'h8000_0000)
                         : (32'(r) << 28) + 32'(r != 0 ? 32'h2000_0000 - 32'h1000_0000 : 0)
                           + ($urandom % 32'h1000_0000);
            do_op("rand", 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                  a, $urandom, $urandom, $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0), 1'b0);
        end

        @(negedge clk);
        req_valid = 1'b1; req_is_write = 1'b0; req_op_size = 2'd2;
        req_addr = 32'h2000_0040; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_bus_req", {31'b0, bus_req}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_bus_req", {31'b0, bus_req}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("mid_rst_no_rsp", pulses, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
